// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   IF/ID pipeline stage built as a DEPTH-entry FIFO of {PC, instruction}
//   pairs. Fetch can run ahead while decode stalls. A flush, used on a branch
//   redirect, empties the queue. When the queue is empty the outputs show an
//   all-zero PC and instruction, which decode as a NOP.
//
//   Optional feature macro: IF_ID_BYPASS_EN
//     defined   : zero-latency bypass from fetch to decode when the queue is
//                 empty and no flush is active.
//     undefined : outputs come only from registered state (1-cycle latency).
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset (highest priority)
//   flush_i      discard all entries; a push in the same cycle is dropped
//   in_valid_i   fetch presents pc_in_i / instr_in_i
//   in_ready_o   queue can accept (registered count != DEPTH)
//   pc_in_i      fetched PC
//   instr_in_i   fetched instruction
//   out_valid_o  head entry available to decode
//   out_ready_i  decode consumes the head (0 = hazard stall)
//   pc_out_o     head PC, 0 when out_valid_o = 0
//   instr_out_o  head instruction, 0 when out_valid_o = 0
//   count_o      occupancy, 0..DEPTH
//
// if_id_queue_chk (same file) holds the simulation-only occupancy assertion.
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter  int PC_W    = 64,
  parameter  int INSTR_W = 32,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_in_i,
  input  logic [INSTR_W-1:0] instr_in_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_out_o,
  output logic [INSTR_W-1:0] instr_out_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic empty_s, full_s, push_s, pop_s, bypass_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));

`ifdef IF_ID_BYPASS_EN
  // Empty queue with live fetch data: decode may see it in the same cycle.
  assign bypass_s = empty_s & in_valid_i & ~flush_i;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed entry that decode accepts right away is never written.
  // in_ready depends on registered count only, so a full queue refuses a
  // push even when a pop happens in the same cycle.
  assign push_s = in_valid_i & ~full_s & ~(bypass_s & out_ready_i);
  assign pop_s  = ~empty_s & out_ready_i;

  // Next-state pointers and occupancy for a normal (no flush/reset) cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_s && !reset_i && !flush_i) begin
      pc_mem_q[wr_ptr_q]    <= pc_in_i;
      instr_mem_q[wr_ptr_q] <= instr_in_i;
    end
  end

  // Head presentation: stored head, else bypassed fetch data, else NOP.
  always_comb begin
    pc_out_o    = {PC_W{1'b0}};
    instr_out_o = {INSTR_W{1'b0}};
    if (!empty_s) begin
      pc_out_o    = pc_mem_q[rd_ptr_q];
      instr_out_o = instr_mem_q[rd_ptr_q];
    end else if (bypass_s) begin
      pc_out_o    = pc_in_i;
      instr_out_o = instr_in_i;
    end else begin
      pc_out_o    = {PC_W{1'b0}};
      instr_out_o = {INSTR_W{1'b0}};
    end
  end

  assign out_valid_o = ~empty_s | bypass_s;
  assign in_ready_o  = ~full_s;
  assign count_o     = count_q;

`ifndef SYNTHESIS
  if_id_queue_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .count_i (count_q)
  );
`endif

endmodule

// -----------------------------------------------------------------------------
// if_id_queue_chk
//   Simulation checker: occupancy never exceeds DEPTH outside reset.
// Ports
//   clk_i    clock
//   reset_i  synchronous reset (check disabled while high)
//   count_i  occupancy register of the queue
// -----------------------------------------------------------------------------
module if_id_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk_i,
  input logic             reset_i,
  input logic [CNT_W-1:0] count_i
);

  // Occupancy bound check on every edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (count_i <= CNT_W'(DEPTH));
    end
  end

endmodule
